// File: rtl/image_pipe_reg_slave.sv
// image_pipe_reg_slave: CPU-bus register slave for the image pipe.
// Holds control/config registers, captures pipe status (busy, sticky
// frame-done, frame counter) and answers writes with a one-cycle wack and
// reads with a one-cycle rdv after RD_LATENCY cycles.
module image_pipe_reg_slave #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic          reg_cpu_clk,
  input  logic          rst_n,
  input  logic          reg_cpu_cs,
  input  logic [AW-1:0] reg_cpu_addr,
  input  logic [DW-1:0] reg_cpu_wr_data,
  input  logic          reg_cpu_we,
  input  logic          reg_cpu_re,
  output logic          reg_cpu_wack,
  output logic          reg_cpu_rdv,
  output logic [DW-1:0] reg_cpu_rd_data,
  input  logic          pipe_busy,
  input  logic          frame_done,
  output logic          cfg_enable,
  output logic          cfg_soft_rst,
  output logic [15:0]   cfg_width,
  output logic [15:0]   cfg_height,
  output logic          irq
);

  // Word index of each register (byte address >> 2).
  localparam logic [5:0] IDX_CTRL   = 6'd0;
  localparam logic [5:0] IDX_WIDTH  = 6'd1;
  localparam logic [5:0] IDX_HEIGHT = 6'd2;
  localparam logic [5:0] IDX_STATUS = 6'd3;
  localparam logic [5:0] IDX_IRQ_ST = 6'd4;
  localparam logic [5:0] IDX_IRQ_EN = 6'd5;
  localparam logic [5:0] IDX_FRAME  = 6'd6;
  localparam int         NREG       = 7;

  localparam logic [15:0] WIDTH_RST  = 16'd640;
  localparam logic [15:0] HEIGHT_RST = 16'd480;

  // Latency counter holds RD_LATENCY-1, at most 7.
  localparam int             CW      = 3;
  localparam logic [CW-1:0]  LAT_LOAD = CW'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_ACK  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_lat_cnt;
  logic [CW-1:0]   w_lat_cnt_next;

  logic            r_ctrl_en;
  logic            r_soft_rst;
  logic [15:0]     r_width;
  logic [15:0]     r_height;
  logic            r_irq_status;
  logic            r_irq_en;
  logic [31:0]     r_frame_cnt;
  logic            r_irq;

  logic            r_wack;
  logic            r_rdv;
  logic [DW-1:0]   r_rd_data;
  logic [DW-1:0]   r_rd_cap;

  logic            w_mapped;
  logic [5:0]      w_idx;
  logic [NREG-1:0] w_sel;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic [DW-1:0]   w_rd_mux;
  logic            w_irq_status_next;
  logic            w_irq_en_next;

  // Only the low 16 data bits are ever stored; the rest are don't-care.
  logic            w_unused_wdata;
  assign w_unused_wdata = ^reg_cpu_wr_data[DW-1:16];

  // Address decode: the upper address bits must be zero and the access
  // word aligned, otherwise the request is acked but touches nothing.
  assign w_mapped = (reg_cpu_addr[AW-1:8] == '0) && (reg_cpu_addr[1:0] == 2'b00);
  assign w_idx    = reg_cpu_addr[7:2];

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sel
      assign w_sel[gi] = w_mapped && (w_idx == 6'(gi));
    end
  endgenerate

  // Requests are only accepted in IDLE; a write wins over a read.
  assign w_wr_acc = (r_state == S_IDLE) && reg_cpu_cs && reg_cpu_we;
  assign w_rd_acc = (r_state == S_IDLE) && reg_cpu_cs && reg_cpu_re && !reg_cpu_we;

  // Read multiplexer: value snapshotted at read acceptance.
  always_comb begin
    w_rd_mux = '0;
    if (w_mapped) begin
      case (w_idx)
        IDX_CTRL:   w_rd_mux[0]     = r_ctrl_en;
        IDX_WIDTH:  w_rd_mux[15:0]  = r_width;
        IDX_HEIGHT: w_rd_mux[15:0]  = r_height;
        IDX_STATUS: w_rd_mux[0]     = pipe_busy;
        IDX_IRQ_ST: w_rd_mux[0]     = r_irq_status;
        IDX_IRQ_EN: w_rd_mux[0]     = r_irq_en;
        IDX_FRAME:  w_rd_mux[31:0]  = r_frame_cnt;
        default:    w_rd_mux        = '0;
      endcase
    end
  end

  // Next values for the interrupt bits; frame_done beats a same-cycle W1C.
  always_comb begin
    w_irq_status_next = r_irq_status;
    w_irq_en_next     = r_irq_en;
    if (w_wr_acc && w_sel[IDX_IRQ_ST] && reg_cpu_wr_data[0]) begin
      w_irq_status_next = 1'b0;
    end
    if (frame_done) begin
      w_irq_status_next = 1'b1;
    end
    if (w_wr_acc && w_sel[IDX_IRQ_EN]) begin
      w_irq_en_next = reg_cpu_wr_data[0];
    end
  end

  // Bus FSM next-state logic and read latency countdown.
  always_comb begin
    w_state_next   = r_state;
    w_lat_cnt_next = r_lat_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_wr_acc) begin
          w_state_next = S_WR_ACK;
        end else if (w_rd_acc) begin
          w_lat_cnt_next = LAT_LOAD;
          w_state_next   = (RD_LATENCY <= 1) ? S_RD_DONE : S_RD_WAIT;
        end
      end
      S_WR_ACK: begin
        w_state_next = S_IDLE;
      end
      S_RD_WAIT: begin
        w_lat_cnt_next = r_lat_cnt - CW'(1);
        if (r_lat_cnt <= CW'(1)) begin
          w_state_next = S_RD_DONE;
        end
      end
      S_RD_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM state, latency counter and read snapshot registers.
  always_ff @(posedge reg_cpu_clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_rd_cap  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_cnt_next;
      if (w_rd_acc) begin
        r_rd_cap <= w_rd_mux;
      end
    end
  end

  // Registered bus responses; rd_data is forced to 0 outside the rdv cycle.
  always_ff @(posedge reg_cpu_clk) begin
    if (!rst_n) begin
      r_wack    <= 1'b0;
      r_rdv     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_wack <= (w_state_next == S_WR_ACK);
      r_rdv  <= (w_state_next == S_RD_DONE);
      if (w_state_next == S_RD_DONE) begin
        // With a latency of one the snapshot and the response share an edge.
        r_rd_data <= w_rd_acc ? w_rd_mux : r_rd_cap;
      end else begin
        r_rd_data <= '0;
      end
    end
  end

  // Control/config registers written from the bus.
  always_ff @(posedge reg_cpu_clk) begin
    if (!rst_n) begin
      r_ctrl_en  <= 1'b0;
      r_soft_rst <= 1'b0;
      r_width    <= WIDTH_RST;
      r_height   <= HEIGHT_RST;
    end else begin
      r_soft_rst <= w_wr_acc && w_sel[IDX_CTRL] && reg_cpu_wr_data[1];
      if (w_wr_acc && w_sel[IDX_CTRL]) begin
        r_ctrl_en <= reg_cpu_wr_data[0];
      end
      if (w_wr_acc && w_sel[IDX_WIDTH]) begin
        r_width <= reg_cpu_wr_data[15:0];
      end
      if (w_wr_acc && w_sel[IDX_HEIGHT]) begin
        r_height <= reg_cpu_wr_data[15:0];
      end
    end
  end

  // Status capture from the pipe core and the registered interrupt line.
  always_ff @(posedge reg_cpu_clk) begin
    if (!rst_n) begin
      r_irq_status <= 1'b0;
      r_irq_en     <= 1'b0;
      r_frame_cnt  <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_irq_status <= w_irq_status_next;
      r_irq_en     <= w_irq_en_next;
      r_irq        <= w_irq_status_next && w_irq_en_next;
      if (frame_done) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
    end
  end

  assign reg_cpu_wack    = r_wack;
  assign reg_cpu_rdv     = r_rdv;
  assign reg_cpu_rd_data = r_rd_data;
  assign cfg_enable      = r_ctrl_en;
  assign cfg_soft_rst    = r_soft_rst;
  assign cfg_width       = r_width;
  assign cfg_height      = r_height;
  assign irq             = r_irq;

endmodule

// File: tb/tb_image_pipe_reg_slave.sv
// Self-checking bench for image_pipe_reg_slave: directed scenarios plus a
// randomized mix checked against a register-level behavioural model.
module tb_image_pipe_reg_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        wack;
  logic        rdv;
  logic [31:0] rd_data;
  logic        pipe_busy = 1'b0;
  logic        frame_done = 1'b0;
  logic        cfg_enable;
  logic        cfg_soft_rst;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the register file.
  logic        m_en;
  logic [15:0] m_width;
  logic [15:0] m_height;
  logic        m_irq_en;
  logic        m_irq_st;
  logic [31:0] m_cnt;

  image_pipe_reg_slave #(.DW(32), .AW(32), .RD_LATENCY(2)) dut (
    .reg_cpu_clk     (clk),
    .rst_n           (rst_n),
    .reg_cpu_cs      (cs),
    .reg_cpu_addr    (addr),
    .reg_cpu_wr_data (wr_data),
    .reg_cpu_we      (we),
    .reg_cpu_re      (re),
    .reg_cpu_wack    (wack),
    .reg_cpu_rdv     (rdv),
    .reg_cpu_rd_data (rd_data),
    .pipe_busy       (pipe_busy),
    .frame_done      (frame_done),
    .cfg_enable      (cfg_enable),
    .cfg_soft_rst    (cfg_soft_rst),
    .cfg_width       (cfg_width),
    .cfg_height      (cfg_height),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_en = 1'b0; m_width = 16'd640; m_height = 16'd480;
    m_irq_en = 1'b0; m_irq_st = 1'b0; m_cnt = 32'd0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    if (a[31:8] != 24'd0 || a[1:0] != 2'b00) return;
    case (a[7:0])
      8'h00: m_en = d[0];
      8'h04: m_width = d[15:0];
      8'h08: m_height = d[15:0];
      8'h10: if (d[0]) m_irq_st = 1'b0;
      8'h14: m_irq_en = d[0];
      default: ;
    endcase
  endfunction

  function automatic void model_frame();
    m_cnt = m_cnt + 32'd1;
    m_irq_st = 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic busy);
    if (a[31:8] != 24'd0 || a[1:0] != 2'b00) return 32'd0;
    case (a[7:0])
      8'h00: return {31'd0, m_en};
      8'h04: return {16'd0, m_width};
      8'h08: return {16'd0, m_height};
      8'h0C: return {31'd0, busy};
      8'h10: return {31'd0, m_irq_st};
      8'h14: return {31'd0, m_irq_en};
      8'h18: return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one write; report what was seen in the ack cycle and after it.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic fd,
                          output logic wack1, output logic soft1, output logic [15:0] width1,
                          output logic extra);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; wr_data = d; frame_done = fd;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; frame_done = 1'b0;
    wack1 = wack; soft1 = cfg_soft_rst; width1 = cfg_width;
    extra = rdv;
    model_write(a, d);
    if (fd) model_frame();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (rdv || wack || cfg_soft_rst) extra = 1'b1;
    end
    $display("WR addr=%h data=%h fd=%0d wack=%0d", a, d, fd, wack1);
  endtask

  // Issue one read; lat=0 means no rdv within the cycle budget.
  task automatic do_read(input logic [31:0] a, input logic busy,
                         output logic [31:0] data, output int lat,
                         output logic wack_any, output logic junk);
    @(negedge clk);
    cs = 1'b1; re = 1'b1; addr = a; pipe_busy = busy;
    lat = 0; data = '0; wack_any = 1'b0; junk = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin cs = 1'b0; re = 1'b0; end
      if (wack) wack_any = 1'b1;
      if (rdv) begin lat = k; data = rd_data; break; end
      else if (rd_data !== 32'd0) junk = 1'b1;
    end
    @(negedge clk);
    $display("RD addr=%h data=%h lat=%0d", a, data, lat);
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_done = 1'b1;
      @(negedge clk); frame_done = 1'b0;
      model_frame();
    end
    $display("FRAME pulses=%0d count=%0d", n, m_cnt);
  endtask

  task automatic test_reset();
    logic [31:0] d; int lat; logic wa, junk;
    rst_n = 1'b0;
    // A write attempted during reset must not land.
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 32'h4; wr_data = 32'hABCD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({wack, rdv, rd_data, cfg_soft_rst, irq, cfg_enable} !== 37'd0) begin
        errors++;
        $display("FAIL reset_outputs: got wack=%b rdv=%b rd=%h soft=%b irq=%b en=%b required all 0",
                 wack, rdv, rd_data, cfg_soft_rst, irq, cfg_enable);
      end
    end
    cs = 1'b0; we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    checks++;
    if (cfg_width !== 16'd640 || cfg_height !== 16'd480) begin
      errors++;
      $display("FAIL reset_cfg: got w=%0d h=%0d required 640 480", cfg_width, cfg_height);
    end
    do_read(32'h4, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd640) begin errors++; $display("FAIL reset_width_rd: got %0d required 640", d); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL reset_rd_latency: got %0d required 2", lat); end
    do_read(32'h8, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd480 || lat !== 2) begin
      errors++; $display("FAIL reset_height_rd: got %0d lat %0d required 480 lat 2", d, lat);
    end
  endtask

  task automatic test_write_read();
    logic wa1, s1, ex, wa, junk; logic [15:0] w1; logic [31:0] d; int lat;
    do_write(32'h4, 32'h0000_1234, 1'b0, wa1, s1, w1, ex);
    checks++;
    if (wa1 !== 1'b1 || ex !== 1'b0) begin
      errors++; $display("FAIL wr_wack: got wack=%b extra=%b required 1 0", wa1, ex);
    end
    checks++;
    if (w1 !== 16'h1234) begin errors++; $display("FAIL wr_cfg_width: got %h required 1234", w1); end
    do_read(32'h4, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== model_read(32'h4, 1'b0) || lat !== 2 || wa !== 1'b0 || junk !== 1'b0) begin
      errors++; $display("FAIL rd_back: got %h lat %0d wack %b junk %b required %h lat 2",
                         d, lat, wa, junk, model_read(32'h4, 1'b0));
    end
  endtask

  task automatic test_unmapped();
    logic wa1, s1, ex, wa, junk; logic [15:0] w1; logic [31:0] d; int lat;
    do_write(32'h20, 32'h0000_FFFF, 1'b0, wa1, s1, w1, ex);
    checks++;
    if (wa1 !== 1'b1) begin errors++; $display("FAIL unm_wack: got %b required 1", wa1); end
    do_write(32'h104, 32'h0000_5555, 1'b0, wa1, s1, w1, ex);
    checks++;
    if (wa1 !== 1'b1 || cfg_width !== m_width) begin
      errors++; $display("FAIL unm_hi_addr: got wack %b width %h required 1 %h", wa1, cfg_width, m_width);
    end
    do_read(32'h20, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd0 || lat !== 2) begin errors++; $display("FAIL unm_rd20: got %h lat %0d required 0 lat 2", d, lat); end
    do_read(32'h6, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd0 || lat !== 2) begin errors++; $display("FAIL unm_rd06: got %h lat %0d required 0 lat 2", d, lat); end
    checks++;
    if (cfg_width !== m_width || cfg_height !== m_height || cfg_enable !== m_en) begin
      errors++; $display("FAIL unm_no_change: got %h %h %b required %h %h %b",
                         cfg_width, cfg_height, cfg_enable, m_width, m_height, m_en);
    end
  endtask

  task automatic test_irq();
    logic wa1, s1, ex, wa, junk; logic [15:0] w1; logic [31:0] d; int lat;
    do_write(32'h14, 32'h1, 1'b0, wa1, s1, w1, ex);
    pulse_frames(3);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
    do_read(32'h18, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd3) begin errors++; $display("FAIL frame_cnt3: got %0d required 3", d); end
    do_write(32'h10, 32'h1, 1'b1, wa1, s1, w1, ex);
    checks++;
    if (irq !== 1'b1 || m_irq_st !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b required 1", irq); end
    do_read(32'h10, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL irq_status_rd: got %h required 1", d); end
    do_read(32'h18, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd4) begin errors++; $display("FAIL frame_cnt4: got %0d required 4", d); end
    do_write(32'h10, 32'h1, 1'b0, wa1, s1, w1, ex);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", irq); end
  endtask

  task automatic test_protocol();
    logic wa, junk, rdv_seen, soft_twice; logic [31:0] d, exp; int lat;
    // Both strobes together: write only.
    @(negedge clk);
    cs = 1'b1; we = 1'b1; re = 1'b1; addr = 32'h0; wr_data = 32'h3;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; re = 1'b0;
    model_write(32'h0, 32'h3);
    checks++;
    if (wack !== 1'b1 || cfg_soft_rst !== 1'b1 || cfg_enable !== 1'b1) begin
      errors++; $display("FAIL both_strobes_ack: got wack %b soft %b en %b required 1 1 1",
                         wack, cfg_soft_rst, cfg_enable);
    end
    rdv_seen = rdv; soft_twice = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rdv) rdv_seen = 1'b1;
      if (cfg_soft_rst) soft_twice = 1'b1;
    end
    $display("WR+RD addr=00000000 data=00000003");
    checks++;
    if (rdv_seen !== 1'b0 || soft_twice !== 1'b0) begin
      errors++; $display("FAIL both_strobes_no_rd: got rdv %b soft_again %b required 0 0", rdv_seen, soft_twice);
    end
    do_read(32'h0, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL ctrl_rd: got %h required 1", d); end
    // A write strobe arriving during the read wait is dropped.
    exp = model_read(32'h4, 1'b0);
    @(negedge clk); cs = 1'b1; re = 1'b1; addr = 32'h4;
    @(negedge clk); re = 1'b0; we = 1'b1; wr_data = 32'hBEEF;
    @(negedge clk); cs = 1'b0; we = 1'b0;
    checks++;
    if (rdv !== 1'b1 || rd_data !== exp || wack !== 1'b0) begin
      errors++; $display("FAIL busy_strobe_rd: got rdv %b data %h wack %b required 1 %h 0", rdv, rd_data, wack, exp);
    end
    @(negedge clk);
    $display("RD addr=00000004 with ignored WR data=0000beef");
    checks++;
    if (wack !== 1'b0 || cfg_width !== m_width) begin
      errors++; $display("FAIL busy_strobe_drop: got wack %b width %h required 0 %h", wack, cfg_width, m_width);
    end
  endtask

  task automatic test_reset_mid_read();
    logic wa1, s1, ex, wa, junk, rdv_seen; logic [15:0] w1; logic [31:0] d; int lat;
    do_write(32'h4, 32'h0777, 1'b0, wa1, s1, w1, ex);
    @(negedge clk); cs = 1'b1; re = 1'b1; addr = 32'h4;
    @(negedge clk); cs = 1'b0; re = 1'b0; rst_n = 1'b0;
    rdv_seen = rdv;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (rdv) rdv_seen = 1'b1;
    end
    model_reset();
    $display("RD addr=00000004 abandoned by reset");
    checks++;
    if (rdv_seen !== 1'b0) begin errors++; $display("FAIL midrd_no_rdv: got %b required 0", rdv_seen); end
    do_read(32'h4, 1'b0, d, lat, wa, junk);
    checks++;
    if (d !== 32'd640 || cfg_width !== 16'd640) begin
      errors++; $display("FAIL midrd_width: got rd %0d cfg %0d required 640", d, cfg_width);
    end
  endtask

  task automatic test_random();
    logic wa1, s1, ex, wa, junk, busy; logic [15:0] w1; logic [31:0] a, d, dat, exp; int lat, op;
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 4));
      if (op == 0) begin
        a = 32'($urandom_range(0, 6)) << 2; d = $urandom;
        if (a == 32'h10) d[0] = 1'b1;
        do_write(a, d, 1'b0, wa1, s1, w1, ex);
        checks++;
        if (wa1 !== 1'b1 || ex !== 1'b0 || s1 !== (a == 32'h0 && d[1])) begin
          errors++; $display("FAIL rnd_wr: addr %h got wack %b extra %b soft %b required 1 0 %b",
                             a, wa1, ex, s1, (a == 32'h0 && d[1]));
        end
      end else if (op == 1 || op == 2) begin
        if (op == 1) a = 32'($urandom_range(0, 7)) << 2;
        else a = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3))
                                             : 32'($urandom) | 32'h100;
        busy = 1'($urandom_range(0, 1));
        exp = model_read(a, busy);
        do_read(a, busy, dat, lat, wa, junk);
        checks++;
        if (dat !== exp || lat !== 2 || wa !== 1'b0 || junk !== 1'b0) begin
          errors++; $display("FAIL rnd_rd: addr %h got %h lat %0d wack %b junk %b required %h lat 2",
                             a, dat, lat, wa, junk, exp);
        end
      end else if (op == 3) begin
        a = 32'($urandom) | 32'h100; d = $urandom;
        do_write(a, d, 1'b0, wa1, s1, w1, ex);
        checks++;
        if (wa1 !== 1'b1 || s1 !== 1'b0) begin
          errors++; $display("FAIL rnd_unm_wr: addr %h got wack %b soft %b required 1 0", a, wa1, s1);
        end
      end else begin
        pulse_frames(int'($urandom_range(1, 3)));
      end
      checks++;
      if (cfg_enable !== m_en || cfg_width !== m_width || cfg_height !== m_height || irq !== (m_irq_st & m_irq_en)) begin
        errors++; $display("FAIL rnd_state: got en %b w %h h %h irq %b required %b %h %h %b",
                           cfg_enable, cfg_width, cfg_height, irq, m_en, m_width, m_height, m_irq_st & m_irq_en);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_unmapped();
    test_irq();
    test_protocol();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
